// File: rtl/uart_core_if.sv
// uart_core_if: byte-level valid/ready handshakes between the UART and on-chip logic
interface uart_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    modport master (
        input  rx_data, rx_valid, rx_frame_err, rx_overrun, tx_ready, tx_busy,
        output rx_ready, tx_data, tx_valid
    );
    modport slave (
        output rx_data, rx_valid, rx_frame_err, rx_overrun, tx_ready, tx_busy,
        input  rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART with one byte of buffering per direction
module uart_core #(
    parameter int BAUDSEL = 625
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    uart_core_if.slave bus
);
    localparam int CW = $clog2(2 * BAUDSEL + 1);
    localparam logic [CW-1:0] HALF = CW'(BAUDSEL);
    localparam logic [CW-1:0] FULL = CW'(2 * BAUDSEL);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t rs, rs_n, ts, ts_n;
    logic rx_m, rx_s;
    logic [CW-1:0] rc, rc_n, tc, tc_n;
    logic [2:0] rb, rb_n, tb, tb_n;
    logic [7:0] rsr, rsr_n, tsr, tsr_n, rd_n;
    logic rv_n, fe_n, ov_n, tx_n, tr_n;
    logic rtick, ttick;
    assign rtick = rc == CW'(1);
    assign ttick = tc == CW'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rs <= IDLE;
            ts <= IDLE;
            rc <= '0;
            tc <= '0;
            rb <= '0;
            tb <= '0;
            rsr <= '0;
            tsr <= '0;
            bus.rx_data <= '0;
            bus.rx_valid <= 1'b0;
            bus.rx_frame_err <= 1'b0;
            bus.rx_overrun <= 1'b0;
            tx <= 1'b1;
            bus.tx_ready <= 1'b1;
            bus.tx_busy <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rs <= rs_n;
            ts <= ts_n;
            rc <= rc_n;
            tc <= tc_n;
            rb <= rb_n;
            tb <= tb_n;
            rsr <= rsr_n;
            tsr <= tsr_n;
            bus.rx_data <= rd_n;
            bus.rx_valid <= rv_n;
            bus.rx_frame_err <= fe_n;
            bus.rx_overrun <= ov_n;
            tx <= tx_n;
            bus.tx_ready <= tr_n;
            bus.tx_busy <= ~tr_n;
        end
    end
    always_comb begin
        rs_n = rs;
        rc_n = (rc != '0) ? rc - CW'(1) : '0;
        rb_n = rb;
        rsr_n = rsr;
        rd_n = bus.rx_data;
        rv_n = bus.rx_valid & ~bus.rx_ready;
        fe_n = 1'b0;
        ov_n = 1'b0;
        case (rs)
            IDLE: if (!rx_s) begin
                rs_n = START;
                rc_n = HALF;
            end
            START: if (rtick) begin
                rs_n = rx_s ? IDLE : DATA;
                rc_n = FULL;
                rb_n = '0;
            end
            DATA: if (rtick) begin
                rsr_n = {rx_s, rsr[7:1]};
                rb_n = rb + 3'd1;
                rc_n = FULL;
                rs_n = (rb == 3'd7) ? STOP : DATA;
            end
            STOP: if (rtick) begin
                // a good stop returns to IDLE at mid-bit so the next start edge is caught
                rs_n = rx_s ? IDLE : STOP;
                fe_n = ~rx_s;
                ov_n = rx_s & bus.rx_valid & ~bus.rx_ready;
                rd_n = (rx_s & ~ov_n) ? rsr : bus.rx_data;
                rv_n = (rx_s & ~ov_n) | rv_n;
            end else if (rc == '0 && rx_s) begin
                rs_n = IDLE;
            end
        endcase
    end
    always_comb begin
        ts_n = ts;
        tc_n = (tc != '0) ? tc - CW'(1) : '0;
        tb_n = tb;
        tsr_n = tsr;
        tx_n = tx;
        tr_n = bus.tx_ready;
        case (ts)
            IDLE: if (bus.tx_valid) begin
                ts_n = START;
                tsr_n = bus.tx_data;
                tx_n = 1'b0;
                tc_n = FULL;
                tr_n = 1'b0;
            end
            START: if (ttick) begin
                ts_n = DATA;
                tx_n = tsr[0];
                tsr_n = tsr >> 1;
                tb_n = '0;
                tc_n = FULL;
            end
            DATA: if (ttick) begin
                ts_n = (tb == 3'd7) ? STOP : DATA;
                tx_n = (tb == 3'd7) ? 1'b1 : tsr[0];
                tsr_n = tsr >> 1;
                tb_n = tb + 3'd1;
                tc_n = FULL;
            end
            STOP: if (tc == CW'(2)) begin
                // ready one clock early so a handshake now starts the next frame with no gap
                ts_n = IDLE;
                tr_n = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: table-driven receive vectors plus overrun and back-to-back transmit sequences
module tb_uart_core;
    localparam int B = 10;
    localparam int BIT = 2 * B;
    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       glitch;
        int         gap;
        int         exp_n;
        int         exp_fe;
    } vec_t;
    typedef struct {
        logic [7:0] d;
        int         mid;
        logic       lat;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic tx;
    uart_core_if bus ();
    uart_core #(.BAUDSEL(B)) dut (.clk(clk), .rst(rst), .rx(rx), .tx(tx), .bus(bus));
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int rx_got = 0;
    logic prev_hs = 1'b0;
    exp_t rx_q[$];
    logic [7:0] tx_q[$];
    vec_t vec[9];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            exp_t e;
            fe_cnt += int'(bus.rx_frame_err);
            ov_cnt += int'(bus.rx_overrun);
            if (prev_hs) check("rx_valid_clear", bus.rx_valid, 0);
            if (bus.rx_valid && bus.rx_ready) begin
                rx_got++;
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got byte %0h expected none", bus.rx_data);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_data", bus.rx_data, e.d);
                    if (e.lat) check("rx_latency", (cyc - e.mid >= 0 && cyc - e.mid <= 12), 1);
                end
            end
            prev_hs = bus.rx_valid & bus.rx_ready;
        end
    end
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic push, input logic lat);
        logic [9:0] f;
        exp_t e;
        f = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            if (i == 9 && push) begin
                e.d = d;
                e.mid = cyc + B;
                e.lat = lat;
                rx_q.push_back(e);
            end
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        int fe0, ov0, n0;
        logic [9:0] fr;
        logic exp_tx;
        vec[0] = '{8'h01, 1'b1, 1'b0, 0, 1, 0};
        vec[1] = '{8'h32, 1'b1, 1'b0, 0, 1, 0};
        vec[2] = '{8'h33, 1'b1, 1'b0, 0, 1, 0};
        vec[3] = '{8'h34, 1'b1, 1'b0, 0, 1, 0};
        vec[4] = '{8'h35, 1'b1, 1'b0, 40, 1, 0};
        vec[5] = '{8'h00, 1'b1, 1'b1, 40, 0, 0};
        vec[6] = '{8'h31, 1'b1, 1'b0, 40, 1, 0};
        vec[7] = '{8'hA5, 1'b0, 1'b0, 40, 0, 1};
        vec[8] = '{8'h5A, 1'b1, 1'b0, 40, 1, 0};
        rst = 1'b1;
        rx = 1'b1;
        bus.rx_ready = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_tx_busy", bus.tx_busy, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_frame_err", bus.rx_frame_err, 0);
        check("rst_overrun", bus.rx_overrun, 0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("idle_tx", tx, 1);
        check("idle_tx_ready", bus.tx_ready, 1);
        check("idle_rx_valid", bus.rx_valid, 0);
        check("idle_frame_err_cnt", fe_cnt, 0);
        check("idle_overrun_cnt", ov_cnt, 0);
        for (int i = 0; i < 9; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            n0 = rx_got;
            if (vec[i].glitch) begin
                rx = 1'b0;
                repeat (5) @(negedge clk);
                rx = 1'b1;
            end else begin
                send_frame(vec[i].data, vec[i].stop, vec[i].stop, 1'b1);
            end
            repeat (vec[i].gap) @(negedge clk);
            check($sformatf("vec%0d_bytes", i), rx_got - n0, vec[i].exp_n);
            check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, vec[i].exp_fe);
            check($sformatf("vec%0d_overrun", i), ov_cnt - ov0, 0);
        end
        check("rx_valid_after_vectors", bus.rx_valid, 0);
        bus.rx_ready = 1'b0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("ovr_pulse", ov_cnt - ov0, 1);
        check("ovr_frame_err", fe_cnt - fe0, 0);
        check("ovr_rx_valid", bus.rx_valid, 1);
        check("ovr_rx_data", bus.rx_data, 8'h11);
        @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_consumed_valid", bus.rx_valid, 0);
        check("rx_queue_empty", rx_q.size(), 0);
        repeat (20) @(negedge clk);
        bus.tx_data = 8'h55;
        bus.tx_valid = 1'b1;
        tx_q.push_back(8'h55);
        tx_q.push_back(8'hC3);
        fr = '1;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (c == 0) bus.tx_data = 8'hC3;
            if (c == 201) bus.tx_valid = 1'b0;
            if (c % 200 == 0 && c < 400) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_queue: got empty expected a byte");
                end else begin
                    fr = {1'b1, tx_q.pop_front(), 1'b0};
                end
            end
            exp_tx = (c >= 400) ? 1'b1 : fr[(c % 200) / BIT];
            if (c % BIT == 0 || c % BIT == B || c % BIT == BIT - 1)
                check($sformatf("tx_bit_c%0d", c), tx, exp_tx);
            if (c % BIT == B) begin
                check($sformatf("tx_ready_c%0d", c), bus.tx_ready, c >= 400);
                check($sformatf("tx_busy_c%0d", c), bus.tx_busy, c < 400);
            end
            if (c == 199 || c == 399) check($sformatf("tx_ready_end_c%0d", c), bus.tx_ready, 1);
        end
        check("tx_queue_empty", tx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex 8N1 UART: one receiver, one transmitter, both timed from a shared half-bit baud divider.
- Sits between a serial pin pair (rx/tx) and on-chip logic.
- Parallel side uses valid/ready byte handshakes.
- No FIFOs: one byte of buffering in each direction.

Parameters:
- BAUDSEL, default 625, clock cycles per half bit period (full bit = 2*BAUDSEL clocks; 625 gives 9600 baud at 12 MHz). Legal range 2..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rx  input  1  serial receive line, idle high, asynchronous to clk
- tx  output  1  serial transmit line, idle high
- rx_data  output  8  last received byte
- rx_valid  output  1  rx_data holds an unconsumed byte
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
- rx_overrun  output  1  one-cycle pulse: byte completed while rx_valid still high
- tx_data  input  8  byte to send
- tx_valid  input  1  tx_data offered
- tx_ready  output  1  transmitter idle; byte taken when tx_valid & tx_ready
- tx_busy  output  1  frame in progress (inverse of tx_ready)

Behaviour:
- Reset (async assert, sync release): tx=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, pulses=0, both FSMs IDLE, all counters 0.
- rx passes through a 2-flop synchronizer, preset to 1 on reset.
- All bit timing is counted from the synchronized signal.

Receiver FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: synchronized rx low starts the frame; load the counter with BAUDSEL.
- START: at the end of BAUDSEL clocks (mid start bit), sample rx:
  - if high, treat as a glitch and return to IDLE;
  - else go to DATA and reload the counter with 2*BAUDSEL.
- DATA: sample 8 bits, each at mid-bit, every 2*BAUDSEL clocks, LSB first, shifted into a shift register.
- STOP: sample at mid stop bit.
  - If high: the byte is good. If rx_valid is 0, or rx_ready is high in that same cycle, load rx_data and set rx_valid. Otherwise drop the new byte, keep the old one, and pulse rx_overrun.
  - If low: discard the byte, pulse rx_frame_err, and wait in STOP until rx returns high before entering IDLE (no false start on a break).
- After a good stop sample, return to IDLE immediately (half-bit early) so back-to-back frames are not missed.
- rx_valid clears on the cycle after the handshake (rx_valid & rx_ready).
- With rx_ready tied high, rx_valid is a one-cycle pulse per byte.

Transmitter FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- Handshake in IDLE latches tx_data. tx goes low on the next clock and tx_ready drops on the same clock.
- Bit order: start bit 0, data bits 0..7, stop bit 1. Each bit is held exactly 2*BAUDSEL clocks. Frame length is 10*2*BAUDSEL clocks.
- tx_ready rises on the clock the stop bit completes. A handshake on that cycle starts the next start bit with no idle gap.
- tx_valid while busy is ignored (no handshake). tx_data only needs to be stable on the handshake cycle.

General:
- Receiver and transmitter are fully independent; simultaneous RX and TX activity is legal.
- Reset mid-frame: tx returns high immediately; any partial received byte is lost.
- Counters are wide enough for 2*BAUDSEL and wrap-free. All outputs are registered.

Test Plan (BAUDSEL=10, bit = 20 clocks):
- Reset held 5 cycles, then idle 200 clocks with rx=1 -> tx=1, tx_ready=1, rx_valid=0, no error/overrun pulses.
- Drive rx frame for 0x01, then '2','3','4','5' (0x32..0x35) back-to-back, rx_ready=1 -> five rx_valid pulses with rx_data 0x01,0x32,0x33,0x34,0x35 in order, each within 12 clocks of the mid stop bit; no errors.
- rx low for 5 clocks then high (glitch) -> no rx_valid, no error; a following 0x31 frame is received correctly.
- rx frame 0xA5 with stop bit driven 0, then rx high -> rx_frame_err one-cycle pulse, rx_valid stays 0; next frame 0x5A is received correctly.
- rx_ready=0, send 0x11 then 0x22 -> rx_valid high with rx_data 0x11, rx_overrun pulse at the second stop bit; raising rx_ready consumes 0x11 and rx_valid drops next cycle.
- Handshake tx_data=0x55 followed by 0xC3 with tx_valid held -> tx shows 0,1,0,1,0,1,0,1,0,1 (20 clocks each), then the 0xC3 frame starts immediately with no idle gap; tx_ready low throughout and high again after 400 clocks total.
